// File: rtl/player_anim_sequencer.sv
// player_anim_sequencer: per-fighter animation state/frame generator, stepped only on frame_tick.
// Optional macro ATK_BUFFER_EN: one-deep attack buffer that survives ATK1/HIT lockout.
module player_anim_sequencer #(
  parameter int unsigned TICKS_PER_FRAME = 4,
  parameter int unsigned IDLE_FRAMES     = 10,
  parameter int unsigned RUN_FRAMES      = 8,
  parameter int unsigned ATK_FRAMES      = 18,
  parameter int unsigned ATK_ACT_START   = 8,
  parameter int unsigned ATK_ACT_END     = 11,
  parameter int unsigned HIT_TICKS       = 20,
  parameter logic        FACE_RIGHT_INIT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       atk_btn,
  input  logic       hit,
  output logic [3:0] anim_state,
  output logic [5:0] anim_frame,
  output logic       facing_right,
  output logic       attack_active,
  output logic       busy
);

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_MOVE = 4'd1,
    ST_ATK1 = 4'd3,
    ST_HIT  = 4'd5
  } state_t;

  localparam logic [3:0] TICK_LAST = 4'(TICKS_PER_FRAME - 1);
  localparam logic [5:0] IDLE_LAST = 6'(IDLE_FRAMES - 1);
  localparam logic [5:0] RUN_LAST  = 6'(RUN_FRAMES - 1);
  localparam logic [5:0] ATK_LAST  = 6'(ATK_FRAMES - 1);
  localparam logic [5:0] ACT_FIRST = 6'(ATK_ACT_START);
  localparam logic [5:0] ACT_LAST  = 6'(ATK_ACT_END);
  localparam logic [5:0] STUN_LOAD = 6'(HIT_TICKS - 1);

`ifdef ATK_BUFFER_EN
  localparam bit ATK_BUF = 1'b1;
`else
  localparam bit ATK_BUF = 1'b0;
`endif

  state_t     state_q, state_d;
  state_t     walk_state, enter_state;
  logic [5:0] frame_q, frame_d;
  logic [5:0] stun_q, stun_d;
  logic [5:0] loop_last;
  logic [3:0] tick_q, tick_d;
  logic       face_q, face_d;
  logic       act_q, act_d;
  logic       busy_q, busy_d;
  logic       atk_pend_q, atk_pend_d;
  logic       hit_pend_q, hit_pend_d;
  logic       atk_prev_q;
  logic       dir_one, atk_ev, hit_ev, tick_last;
  logic       enter, seq_done;

  // Events arriving in the tick cycle itself count as already pending.
  always_comb begin
    dir_one    = move_left ^ move_right;
    walk_state = dir_one ? ST_MOVE : ST_IDLE;
    atk_ev     = atk_pend_q | (atk_btn & ~atk_prev_q);
    hit_ev     = hit_pend_q | hit;
    tick_last  = (tick_q == TICK_LAST);
    loop_last  = (state_q == ST_MOVE) ? RUN_LAST : IDLE_LAST;
  end

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    tick_d      = tick_q;
    stun_d      = stun_q;
    face_d      = face_q;
    atk_pend_d  = atk_ev;
    hit_pend_d  = hit_ev;
    enter       = 1'b0;
    enter_state = state_q;
    seq_done    = 1'b0;

    if (frame_tick) begin
      hit_pend_d = 1'b0;
      if ((state_q == ST_IDLE || state_q == ST_MOVE) && dir_one) begin
        face_d = move_right;
      end

      if (hit_ev) begin
        enter       = 1'b1;
        enter_state = ST_HIT;
        if (!ATK_BUF) atk_pend_d = 1'b0;
      end else if (state_q == ST_ATK1 || state_q == ST_HIT) begin
        if (!ATK_BUF) atk_pend_d = 1'b0;
        tick_d = tick_last ? '0 : tick_q + 4'd1;
        if (state_q == ST_ATK1) begin
          if (tick_last) begin
            if (frame_q == ATK_LAST) seq_done = 1'b1;
            else                     frame_d  = frame_q + 6'd1;
          end
        end else begin
          if (stun_q == '0) seq_done = 1'b1;
          else              stun_d   = stun_q - 6'd1;
        end
        if (seq_done) begin
          enter = 1'b1;
          if (ATK_BUF && atk_ev) begin
            enter_state = ST_ATK1;
            atk_pend_d  = 1'b0;
          end else begin
            enter_state = walk_state;
          end
        end
      end else if (atk_ev) begin
        enter       = 1'b1;
        enter_state = ST_ATK1;
        atk_pend_d  = 1'b0;
      end else if (walk_state != state_q) begin
        enter       = 1'b1;
        enter_state = walk_state;
      end else begin
        tick_d = tick_last ? '0 : tick_q + 4'd1;
        if (tick_last) frame_d = (frame_q == loop_last) ? '0 : frame_q + 6'd1;
      end

      // Stun reload on every entry is harmless outside HIT and keeps the path simple.
      if (enter) begin
        state_d = enter_state;
        frame_d = '0;
        tick_d  = '0;
        stun_d  = STUN_LOAD;
      end
    end

    act_d  = (state_d == ST_ATK1) && (frame_d >= ACT_FIRST) && (frame_d <= ACT_LAST);
    busy_d = (state_d == ST_ATK1) || (state_d == ST_HIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      frame_q    <= '0;
      tick_q     <= '0;
      stun_q     <= '0;
      face_q     <= FACE_RIGHT_INIT;
      act_q      <= 1'b0;
      busy_q     <= 1'b0;
      atk_pend_q <= 1'b0;
      hit_pend_q <= 1'b0;
      atk_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      tick_q     <= tick_d;
      stun_q     <= stun_d;
      face_q     <= face_d;
      act_q      <= act_d;
      busy_q     <= busy_d;
      atk_pend_q <= atk_pend_d;
      hit_pend_q <= hit_pend_d;
      atk_prev_q <= atk_btn;
    end
  end

  assign anim_state    = state_q;
  assign anim_frame    = frame_q;
  assign facing_right  = face_q;
  assign attack_active = act_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_player_anim_sequencer.sv
// Scoreboard bench for player_anim_sequencer: age-based reference model, directed scenarios, random traffic.
module tb_player_anim_sequencer;

  localparam int TPF    = 4;
  localparam int IDLE_N = 10;
  localparam int RUN_N  = 8;
  localparam int ATK_N  = 18;
  localparam int ACT_S  = 8;
  localparam int ACT_E  = 11;
  localparam int HIT_N  = 20;
  localparam bit FACE_INIT = 1'b1;
`ifdef ATK_BUFFER_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       move_left = 1'b0;
  logic       move_right = 1'b0;
  logic       atk_btn = 1'b0;
  logic       hit = 1'b0;
  logic [3:0] anim_state;
  logic [5:0] anim_frame;
  logic       facing_right, attack_active, busy;

  int checks = 0;
  int errors = 0;

  player_anim_sequencer #(
    .TICKS_PER_FRAME(TPF),
    .IDLE_FRAMES(IDLE_N),
    .RUN_FRAMES(RUN_N),
    .ATK_FRAMES(ATK_N),
    .ATK_ACT_START(ACT_S),
    .ATK_ACT_END(ACT_E),
    .HIT_TICKS(HIT_N),
    .FACE_RIGHT_INIT(FACE_INIT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .frame_tick(frame_tick),
    .move_left(move_left),
    .move_right(move_right),
    .atk_btn(atk_btn),
    .hit(hit),
    .anim_state(anim_state),
    .anim_frame(anim_frame),
    .facing_right(facing_right),
    .attack_active(attack_active),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int st;
    int fr;
    bit face;
    bit act;
    bit busy;
  } exp_t;
  exp_t sb[$];

  // Reference model: state plus age (ticks since entry); frame is derived from age.
  int m_st, m_age;
  bit m_face, m_atk, m_hit, m_prev;

  function automatic int exp_frame(input int st, input int age);
    case (st)
      0:       return (age / TPF) % IDLE_N;
      1:       return (age / TPF) % RUN_N;
      3:       return age / TPF;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_age = 0; m_face = FACE_INIT;
      m_atk = 0; m_hit = 0; m_prev = 0;
      sb.delete();
    end else begin
      bit ae, he, one, done;
      int walk;
      exp_t e;
      ae = m_atk || (atk_btn && !m_prev);
      he = m_hit || hit;
      m_prev = atk_btn;
      if (!frame_tick) begin
        m_atk = ae;
        m_hit = he;
      end else begin
        one  = (move_left != move_right);
        walk = one ? 1 : 0;
        if ((m_st == 0 || m_st == 1) && one) m_face = move_right;
        if (he) begin
          m_st = 5; m_age = 0;
          if (!BUF) ae = 0;
        end else if (m_st == 3 || m_st == 5) begin
          if (!BUF) ae = 0;
          m_age++;
          done = (m_st == 3) ? (m_age == ATK_N * TPF) : (m_age == HIT_N);
          if (done) begin
            if (BUF && ae) begin m_st = 3; ae = 0; end
            else m_st = walk;
            m_age = 0;
          end
        end else if (ae) begin
          m_st = 3; m_age = 0; ae = 0;
        end else if (walk != m_st) begin
          m_st = walk; m_age = 0;
        end else begin
          m_age++;
        end
        m_atk = ae;
        m_hit = 0;
        e.st   = m_st;
        e.fr   = exp_frame(m_st, m_age);
        e.face = m_face;
        e.act  = (m_st == 3) && (e.fr >= ACT_S) && (e.fr <= ACT_E);
        e.busy = (m_st == 3) || (m_st == 5);
        sb.push_back(e);
      end
    end
  end

  // Monitor: outputs settle one clk after each tick; compare them against the queued prediction.
  always @(negedge clk) begin
    if (rst_n && sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("sb_state",  int'(anim_state),    e.st);
      chk("sb_frame",  int'(anim_frame),    e.fr);
      chk("sb_facing", int'(facing_right),  int'(e.face));
      chk("sb_active", int'(attack_active), int'(e.act));
      chk("sb_busy",   int'(busy),          int'(e.busy));
    end
  end

  task automatic pulse_tick(input bit with_hit);
    @(negedge clk);
    frame_tick = 1'b1;
    hit = with_hit;
    @(negedge clk);
    frame_tick = 1'b0;
    hit = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) pulse_tick(1'b0);
  endtask

  task automatic press_atk();
    @(negedge clk);
    atk_btn = 1'b1;
    @(negedge clk);
    atk_btn = 1'b0;
  endtask

  task automatic pulse_hit();
    @(negedge clk);
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"},  int'(anim_state),    0);
    chk({tag, "_frame"},  int'(anim_frame),    0);
    chk({tag, "_facing"}, int'(facing_right),  int'(FACE_INIT));
    chk({tag, "_active"}, int'(attack_active), 0);
    chk({tag, "_busy"},   int'(busy),          0);
  endtask

  initial begin
    int cnt, first, exit_at;
    bit face_before;

    repeat (3) @(negedge clk);
    chk_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // T2: run right for 40 ticks
    move_right = 1'b1;
    for (int i = 0; i < 40; i++) begin
      pulse_tick(1'b0);
      if (i == 0)  chk("t2_enter_state", int'(anim_state), 1);
      if (i == 31) chk("t2_frame31", int'(anim_frame), 7);
      if (i == 32) chk("t2_frame32", int'(anim_frame), 0);
      if (i == 36) chk("t2_frame36", int'(anim_frame), 1);
    end
    chk("t2_facing", int'(facing_right), 1);
    move_right = 1'b0;
    ticks(1);

    // T3: attack from IDLE, active window and one-shot length
    press_atk();
    cnt = 0; first = -1; exit_at = -1;
    for (int i = 0; i < 80; i++) begin
      pulse_tick(1'b0);
      if (i == 0) chk("t3_enter_state", int'(anim_state), 3);
      if (attack_active) begin
        cnt++;
        if (first < 0) first = i;
      end
      if (exit_at < 0 && anim_state == 4'd0) exit_at = i;
    end
    chk("t3_active_count", cnt, 16);
    chk("t3_active_first", first, 32);
    chk("t3_exit_tick", exit_at, 72);

    // T4: hit at ATK1 frame 5, re-hit after 10 ticks restarts stun
    press_atk();
    pulse_tick(1'b0);
    ticks(20);
    chk("t4_atk_frame", int'(anim_frame), 5);
    pulse_hit();
    pulse_tick(1'b0);
    chk("t4_hit_state", int'(anim_state), 5);
    ticks(9);
    pulse_tick(1'b1);
    exit_at = -1;
    for (int i = 1; i <= 25; i++) begin
      pulse_tick(1'b0);
      if (exit_at < 0 && anim_state != 4'd5) exit_at = i;
    end
    chk("t4_stun_exit", exit_at, 20);

    // T5: press during ATK1
    press_atk();
    pulse_tick(1'b0);
    ticks(10);
    press_atk();
    ticks(61);
    chk("t5_still_atk", int'(anim_state), 3);
    pulse_tick(1'b0);
    chk("t5_after_state", int'(anim_state), BUF ? 3 : 0);
    chk("t5_after_frame", int'(anim_frame), 0);
    ticks(75);

    // T6: both directions held, then hit coincident with the tick
    move_left = 1'b1;
    pulse_tick(1'b0);
    chk("t6_face_left", int'(facing_right), 0);
    face_before = facing_right;
    move_right = 1'b1;
    ticks(3);
    chk("t6_both_idle", int'(anim_state), 0);
    chk("t6_face_kept", int'(facing_right), int'(face_before));
    pulse_tick(1'b1);
    chk("t6_hit_state", int'(anim_state), 5);
    chk("t6_hit_face", int'(facing_right), int'(face_before));
    move_left = 1'b0; move_right = 1'b0;
    ticks(22);

    // T1: reset in the middle of ATK1 frame 7
    move_left = 1'b1;
    pulse_tick(1'b0);
    move_left = 1'b0;
    press_atk();
    pulse_tick(1'b0);
    ticks(28);
    chk("t1_pre_state", int'(anim_state), 3);
    chk("t1_pre_frame", int'(anim_frame), 7);
    chk("t1_pre_face", int'(facing_right), 0);
    #2 rst_n = 1'b0;
    #1 chk_reset("t1_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset("t1_post");

    // Random traffic, including held ticks and a mid-run reset
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      frame_tick = ($urandom_range(0, 3) == 0);
      hit        = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 7) == 0)  atk_btn    = ~atk_btn;
      if ($urandom_range(0, 15) == 0) move_left  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) move_right = 1'($urandom_range(0, 1));
      if (c == 2000) #2 rst_n = 1'b0;
      if (c == 2003) rst_n = 1'b1;
    end
    frame_tick = 1'b0;
    hit = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
